// File: rtl/line_buffer_3row_pkg.sv
// Shared image-pipeline constants: frame geometry for the line buffer and
// kernel settings for the Laplacian stage that consumes its 3-row columns.
package line_buffer_3row_pkg;

  localparam int DEF_WIDTH      = 24;
  localparam int DEF_PIC_WIDTH  = 640;
  localparam int DEF_PIC_HEIGHT = 480;

  typedef enum logic [0:0] {
    LAP_4N = 1'b0,
    LAP_8N = 1'b1
  } lap_kernel_e;

  localparam lap_kernel_e LAP_DEF_KERNEL = LAP_8N;
  localparam int          LAP_CENTER_4N  = 4;
  localparam int          LAP_CENTER_8N  = 8;

  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/line_buffer_3row_ram.sv
// Simple dual-port line memory with a registered, read-old-data read port.
// Only the read register is reset; array contents survive reset.
module line_ram
  import line_buffer_3row_pkg::*;
#(
  parameter int DEPTH = DEF_PIC_WIDTH,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we,
  input  logic [addr_bits(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  input  logic [addr_bits(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]           rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q, rd_data_d;

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/line_buffer_3row.sv
// Three-row line buffer: emits one vertically aligned column (lines n-2, n-1, n)
// per accepted raster pixel, one cycle after the pixel arrives.
module line_buffer_3row
  import line_buffer_3row_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int PIC_WIDTH  = DEF_PIC_WIDTH,
  parameter int PIC_HEIGHT = DEF_PIC_HEIGHT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sof,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] din,
  output logic             valid_out,
  output logic [WIDTH-1:0] dout1,
  output logic [WIDTH-1:0] dout2,
  output logic [WIDTH-1:0] dout3
);

  localparam int COL_W = addr_bits(PIC_WIDTH);
  localparam int ROW_W = addr_bits(PIC_HEIGHT);

  logic [COL_W-1:0] col_q, col_d, cur_col;
  logic [ROW_W-1:0] row_q, row_d, cur_row;
  logic             valid_out_q, valid_out_d;
  logic [WIDTH-1:0] dout3_q, dout3_d;
  logic             l2_wr_pend_q, l2_wr_pend_d;
  logic [COL_W-1:0] l2_wr_addr_q, l2_wr_addr_d;
  logic             fwd_sel_q, fwd_sel_d;
  logic [WIDTH-1:0] fwd_data_q, fwd_data_d;
  logic [WIDTH-1:0] l1_rd_data, l2_rd_data;

  assign cur_col = sof ? '0 : col_q;
  assign cur_row = sof ? '0 : row_q;

  // Old L1 data only appears a cycle after the read, so the L2 write is
  // deferred one cycle; a same-column read in that cycle is forwarded.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    valid_out_d  = 1'b0;
    dout3_d      = dout3_q;
    l2_wr_pend_d = valid_in;
    l2_wr_addr_d = cur_col;
    fwd_sel_d    = fwd_sel_q;
    fwd_data_d   = fwd_data_q;
    if (valid_in) begin
      dout3_d     = din;
      valid_out_d = (32'(cur_row) >= 32'd2);
      fwd_sel_d   = l2_wr_pend_q && (l2_wr_addr_q == cur_col);
      fwd_data_d  = l1_rd_data;
      if (cur_col == COL_W'(PIC_WIDTH - 1)) begin
        col_d = '0;
        row_d = (cur_row == ROW_W'(PIC_HEIGHT - 1)) ? '0 : cur_row + ROW_W'(1);
      end else begin
        col_d = cur_col + COL_W'(1);
        row_d = cur_row;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      valid_out_q  <= 1'b0;
      dout3_q      <= '0;
      l2_wr_pend_q <= 1'b0;
      l2_wr_addr_q <= '0;
      fwd_sel_q    <= 1'b0;
      fwd_data_q   <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      valid_out_q  <= valid_out_d;
      dout3_q      <= dout3_d;
      l2_wr_pend_q <= l2_wr_pend_d;
      l2_wr_addr_q <= l2_wr_addr_d;
      fwd_sel_q    <= fwd_sel_d;
      fwd_data_q   <= fwd_data_d;
    end
  end

  line_ram #(.DEPTH(PIC_WIDTH), .WIDTH(WIDTH)) u_l1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (valid_in),
    .wr_addr (cur_col),
    .wr_data (din),
    .rd_en   (valid_in),
    .rd_addr (cur_col),
    .rd_data (l1_rd_data)
  );

  line_ram #(.DEPTH(PIC_WIDTH), .WIDTH(WIDTH)) u_l2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (l2_wr_pend_q),
    .wr_addr (l2_wr_addr_q),
    .wr_data (l1_rd_data),
    .rd_en   (valid_in),
    .rd_addr (cur_col),
    .rd_data (l2_rd_data)
  );

  assign valid_out = valid_out_q;
  assign dout3     = dout3_q;
  assign dout2     = l1_rd_data;
  assign dout1     = fwd_sel_q ? fwd_data_q : l2_rd_data;

endmodule

// File: tb/tb_line_buffer_3row.sv
// Directed bench for line_buffer_3row on a 4x4 frame with pixel = base+row*16+col.
module tb_line_buffer_3row;

  localparam int WIDTH = 24;
  localparam int PW    = 4;
  localparam int PH    = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             sof;
  logic             valid_in;
  logic [WIDTH-1:0] din;
  logic             valid_out;
  logic [WIDTH-1:0] dout1, dout2, dout3;

  int errors = 0;
  int checks = 0;

  line_buffer_3row #(.WIDTH(WIDTH), .PIC_WIDTH(PW), .PIC_HEIGHT(PH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sof       (sof),
    .valid_in  (valid_in),
    .din       (din),
    .valid_out (valid_out),
    .dout1     (dout1),
    .dout2     (dout2),
    .dout3     (dout3)
  );

  always #5 clk = ~clk;

  // Drives one cycle of input, then samples just after the capturing edge.
  task automatic applyStimulus(input logic v, input logic s, input logic [WIDTH-1:0] d);
    valid_in = v;
    sof      = s;
    din      = d;
    @(posedge clk);
    #1;
  endtask

  task automatic sendPixel(input int base, input int r, input int c, input logic s);
    applyStimulus(1'b1, s, WIDTH'(base + r * 16 + c));
  endtask

  task automatic checkValue(input string tag, input logic [WIDTH-1:0] obs,
                            input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic exp_valid, input logic check_data,
                             input int e1, input int e2, input int e3);
    checks++;
    assert (valid_out === exp_valid) else begin
      errors++;
      $error("[TB] FAIL %s valid_out: observed=%b expected=%b", tag, valid_out, exp_valid);
    end
    if (check_data) begin
      checkValue({tag, " dout1"}, dout1, WIDTH'(e1));
      checkValue({tag, " dout2"}, dout2, WIDTH'(e2));
      checkValue({tag, " dout3"}, dout3, WIDTH'(e3));
    end
  endtask

  // Column at (r,c) for a frame whose rows r-2..r all used the same base.
  task automatic checkColumn(input string tag, input int base, input int r, input int c);
    checkOutput(tag, 1'b1, 1'b1, base + (r - 2) * 16 + c, base + (r - 1) * 16 + c,
                base + r * 16 + c);
  endtask

  initial begin
    rst_n    = 1'b0;
    sof      = 1'b0;
    valid_in = 1'b0;
    din      = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 1'b0, 1'b1, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill rows 0-1: nothing valid yet.
    for (int i = 0; i < 8; i++) begin
      sendPixel(0, i / PW, i % PW, (i == 0));
      checkOutput($sformatf("fill px%0d", i), 1'b0, 1'b0, 0, 0, 0);
    end
    sendPixel(0, 2, 0, 1'b0);
    checkColumn("fill (2,0)", 0, 2, 0);
    sendPixel(0, 2, 1, 1'b0);
    checkOutput("fill (2,1)", 1'b1, 1'b1, 'h01, 'h11, 'h21);

    // Gaps, including a sof without valid_in which must be ignored.
    for (int g = 0; g < 3; g++) begin
      applyStimulus(1'b0, (g == 1), 24'hABCDEF);
      checkOutput($sformatf("gap%0d", g), 1'b0, 1'b1, 'h01, 'h11, 'h21);
    end
    sendPixel(0, 2, 2, 1'b0);
    checkOutput("gap (2,2)", 1'b1, 1'b1, 'h02, 'h12, 'h22);
    sendPixel(0, 2, 3, 1'b0);
    checkColumn("row2 (2,3)", 0, 2, 3);
    for (int c = 0; c < PW; c++) begin
      sendPixel(0, 3, c, 1'b0);
      checkColumn($sformatf("row3 (3,%0d)", c), 0, 3, c);
    end
    checkOutput("wrap (3,3)", 1'b1, 1'b1, 'h13, 'h23, 'h33);

    // Natural frame wrap without sof.
    for (int i = 0; i < 8; i++) begin
      sendPixel(0, i / PW, i % PW, 1'b0);
      checkOutput($sformatf("wrap px%0d", i), 1'b0, 1'b0, 0, 0, 0);
    end
    sendPixel(0, 2, 0, 1'b0);
    checkOutput("wrap (2,0)", 1'b1, 1'b1, 'h00, 'h10, 'h20);
    sendPixel(0, 2, 1, 1'b0);
    sendPixel(0, 2, 2, 1'b0);
    sendPixel(0, 2, 3, 1'b0);
    sendPixel(0, 3, 0, 1'b0);
    sendPixel(0, 3, 1, 1'b0);
    checkColumn("pre-sof (3,1)", 0, 3, 1);

    // sof where (3,2) was expected restarts the frame at (0,0).
    for (int i = 0; i < 8; i++) begin
      sendPixel('h80, i / PW, i % PW, (i == 0));
      checkOutput($sformatf("sof px%0d", i), 1'b0, 1'b0, 0, 0, 0);
    end
    sendPixel('h80, 2, 0, 1'b0);
    checkColumn("sof (2,0)", 'h80, 2, 0);
    sendPixel('h80, 2, 1, 1'b0);
    checkColumn("sof (2,1)", 'h80, 2, 1);

    // Asynchronous reset mid-line takes effect without a clock edge.
    valid_in = 1'b0;
    rst_n    = 1'b0;
    #1;
    checkOutput("async reset", 1'b0, 1'b1, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      sendPixel('h100, i / PW, i % PW, 1'b0);
      checkOutput($sformatf("post-rst px%0d", i), 1'b0, 1'b0, 0, 0, 0);
    end
    sendPixel('h100, 2, 0, 1'b0);
    checkColumn("post-rst (2,0)", 'h100, 2, 0);
    sendPixel('h100, 2, 1, 1'b0);
    checkColumn("post-rst (2,1)", 'h100, 2, 1);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("post-rst idle", 1'b0, 1'b1, 'h101, 'h111, 'h121);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/line_buffer_3row.md
LINE_BUFFER_3ROW -- requirements
Module: line_buffer_3row

Interface
REQ-001 SHALL have parameter WIDTH, default 24: pixel width in bits (RGB888).
REQ-002 SHALL have parameter PIC_WIDTH, default 640: pixels per line.
REQ-003 SHALL have parameter PIC_HEIGHT, default 480: lines per frame.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port sof, input, 1: start-of-frame pulse, qualified by valid_in.
REQ-007 SHALL have port valid_in, input, 1: din carries a pixel this cycle.
REQ-008 SHALL have port din, input, WIDTH: raster-order pixel stream.
REQ-009 SHALL have port valid_out, output, 1: dout1..dout3 hold one aligned column.
REQ-010 SHALL have port dout1, output, WIDTH: pixel from line n-2 (top row).
REQ-011 SHALL have port dout2, output, WIDTH: pixel from line n-1 (middle row).
REQ-012 SHALL have port dout3, output, WIDTH: pixel from line n (current, bottom row).

Function
REQ-013 SHALL keep column counter col (0..PIC_WIDTH-1) and row counter row (0..PIC_HEIGHT-1), both advanced only on accepted pixels (valid_in=1).
REQ-014 SHALL increment col on each accepted pixel; at PIC_WIDTH-1, wrap col to 0 and increment row.
REQ-015 SHALL wrap row to 0 when col wraps on row PIC_HEIGHT-1 (end of frame).
REQ-016 SHALL hold col, row, outputs and valid_out=0 while valid_in=0; gaps anywhere mid-line are legal.
REQ-017 SHALL treat valid_in=1 with sof=1 as pixel (0,0) of a new frame regardless of current col/row; after it col=1, row=0. sof with valid_in=0 is ignored.
REQ-018 SHALL hold two line memories, L1 (line n-1) and L2 (line n-2), each PIC_WIDTH x WIDTH, addressed by col.
REQ-019 SHALL, on accepted pixel at column c: read L1[c] and L2[c] (old contents), write L1[c]<=din and L2[c]<=old L1[c] in the same cycle; read-before-write.
REQ-020 SHALL register outputs with 1-cycle latency: dout3<=din, dout2<=old L1[c], dout1<=old L2[c].
REQ-021 SHALL assert valid_out one cycle after an accepted pixel with row>=2 (sof pixel counts as row 0), else drive 0.
REQ-022 SHALL keep dout1..dout3 unchanged in cycles with no accepted pixel.
REQ-023 SHALL sustain one pixel per clock, no backpressure.

Reset
REQ-024 SHALL, on rst_n=0, immediately clear col, row, valid_out and dout1..dout3 to 0.
REQ-025 SHALL NOT reset line memory contents; stale data is masked by REQ-021.
REQ-026 SHALL, after reset deassertion (including mid-frame), treat the next accepted pixel as (0,0).

Structure
REQ-027 SHALL take WIDTH, PIC_WIDTH, PIC_HEIGHT defaults from the shared image-pipeline package, alongside the Laplacian stage's constants.
REQ-028 SHALL instantiate sub-module line_ram (simple dual-port, depth PIC_WIDTH, width WIDTH, synchronous read-old-data) twice for L1 and L2.
REQ-029 SHALL size counters as clog2(PIC_WIDTH) and clog2(PIC_HEIGHT) bits.

Verification (PIC_WIDTH=4, PIC_HEIGHT=4, WIDTH=24, pixel value = row*16+col)
REQ-030 SHALL check reset: rst_n=0 mid-stream -> same cycle all outputs 0, valid_out=0.
REQ-031 SHALL check fill: stream rows 0-2 contiguously -> valid_out=0 for first 8 pixels; cycle after pixel (2,1), dout1=0x01, dout2=0x11, dout3=0x21, valid_out=1.
REQ-032 SHALL check gaps: valid_in=0 for 3 cycles after pixel (2,1) -> valid_out=0 and outputs hold 0x01/0x11/0x21; pixel (2,2) then yields 0x02/0x12/0x22.
REQ-033 SHALL check frame wrap: after pixel (3,3) (outputs 0x13/0x23/0x33), next frame's first 8 pixels -> valid_out=0; pixel (2,0) of new frame -> 0x00/0x10/0x20.
REQ-034 SHALL check sof resync: sof=1 with valid_in at pixel (3,2) -> treated as (0,0), valid_out=0 for 8 accepted pixels, then aligned output resumes.
REQ-035 SHALL check reset mid-line: rst_n pulse after pixel (2,1), then restart streaming -> valid_out=0 for first 8 pixels, then outputs match the new stream.
